// File: rtl/mult_share_arbiter_if.sv
// Requester/multiplier-side bundle for mult_share_arbiter.
// slave = arbiter side, master = requesters plus the multiplier that feeds mult_prod.
interface mult_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_prod;
    logic [DATA_WIDTH-1:0]         mult_a;
    logic [DATA_WIDTH-1:0]         mult_b;
    logic                          mult_issue;
    logic [DATA_WIDTH-1:0]         mult_prod;
    logic                          busy;

    modport slave (
        input  req, req_a, req_b, mult_prod,
        output grant, resp_valid, resp_prod, mult_a, mult_b, mult_issue, busy
    );

    modport master (
        output req, req_a, req_b, mult_prod,
        input  grant, resp_valid, resp_prod, mult_a, mult_b, mult_issue, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters; products are routed back by a tag pipeline.
// Define MULT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module mult_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MULT_DELAY = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mult_share_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    logic [NUM_REQ-1:0]    pending_q, pending_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_prod_q, resp_prod_d;
    logic [DATA_WIDTH-1:0] mult_a_q, mult_a_d;
    logic [DATA_WIDTH-1:0] mult_b_q, mult_b_d;
    logic                  mult_issue_q, mult_issue_d;
    idx_t                  issue_idx_q, issue_idx_d;
    logic                  tag_valid_q [MULT_DELAY];
    logic                  tag_valid_d [MULT_DELAY];
    idx_t                  tag_idx_q   [MULT_DELAY];
    idx_t                  tag_idx_d   [MULT_DELAY];

    logic [NUM_REQ-1:0]    eligible;
    logic                  win_found;
    idx_t                  win_idx;

`ifdef MULT_ARB_FIXED_PRIORITY_EN
    always_comb begin
        eligible  = bus.req & ~pending_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = idx_t'(i);
            end
        end
    end
`else
    idx_t last_q, last_d;

    // Scan backwards so the candidate right after last_q is the one that sticks.
    always_comb begin
        eligible  = bus.req & ~pending_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (eligible[(int'(last_q) + i) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = idx_t'((int'(last_q) + i) % NUM_REQ);
            end
        end
        last_d = win_found ? win_idx : last_q;
    end

    always_ff @(posedge clock) begin
        if (reset) last_q <= idx_t'(NUM_REQ - 1);
        else       last_q <= last_d;
    end
`endif

    always_comb begin
        pending_d    = pending_q;
        grant_d      = '0;
        resp_valid_d = '0;
        resp_prod_d  = resp_prod_q;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        mult_issue_d = win_found;
        issue_idx_d  = win_idx;

        if (tag_valid_q[MULT_DELAY-1]) begin
            resp_valid_d[tag_idx_q[MULT_DELAY-1]] = 1'b1;
            resp_prod_d                           = bus.mult_prod;
            pending_d[tag_idx_q[MULT_DELAY-1]]    = 1'b0;
        end
        if (win_found) begin
            grant_d[win_idx]   = 1'b1;
            pending_d[win_idx] = 1'b1;
            mult_a_d = bus.req_a[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            mult_b_d = bus.req_b[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end

        // Stage 0 follows the issue cycle, so the last stage lines up with mult_prod.
        tag_valid_d[0] = mult_issue_q;
        tag_idx_d[0]   = issue_idx_q;
        for (int s = 1; s < MULT_DELAY; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_idx_d[s]   = tag_idx_q[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q    <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_prod_q  <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_issue_q <= 1'b0;
            issue_idx_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_prod_q  <= resp_prod_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_issue_q <= mult_issue_d;
            issue_idx_q  <= issue_idx_d;
        end
    end

    for (genvar gi = 0; gi < MULT_DELAY; gi++) begin : g_tag
        always_ff @(posedge clock) begin
            if (reset) begin
                tag_valid_q[gi] <= 1'b0;
                tag_idx_q[gi]   <= '0;
            end else begin
                tag_valid_q[gi] <= tag_valid_d[gi];
                tag_idx_q[gi]   <= tag_idx_d[gi];
            end
        end
    end

    assign bus.grant      = grant_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_prod  = resp_prod_q;
    assign bus.mult_a     = mult_a_q;
    assign bus.mult_b     = mult_b_q;
    assign bus.mult_issue = mult_issue_q;
    assign bus.busy       = |pending_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter against a transaction-level model (in-flight list with due times).
// Also models the pipelined multiplier; honours MULT_ARB_FIXED_PRIORITY_EN.
module tb_mult_share_arbiter;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MD = 4;

    logic clock;
    logic reset;
    mult_share_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    mult_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_DELAY(MD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Multiplier: product emerges exactly MD cycles after issue; junk otherwise.
    logic [DW-1:0] mpipe [MD];
    always @(posedge clock) begin
        mpipe[0] <= bus.mult_issue ? DW'(bus.mult_a * bus.mult_b) : DW'($urandom);
        for (int s = 1; s < MD; s++) mpipe[s] <= mpipe[s-1];
    end
    assign bus.mult_prod = mpipe[MD-1];

    typedef struct {
        int            idx;
        logic [DW-1:0] prod;
        int            due;
    } op_t;

    op_t           inflight [$];
    logic [NR-1:0] m_pending;
    int            m_last;
    int            edge_n;
    logic [NR-1:0] exp_grant, exp_resp_valid;
    logic [DW-1:0] exp_resp_prod, exp_mult_a, exp_mult_b;
    logic          exp_issue, exp_busy;
    logic [DW-1:0] op_a [NR];
    logic [DW-1:0] op_b [NR];
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    // Advance the model over the coming clock edge using the inputs currently driven.
    task automatic model_step();
        logic [NR-1:0] elig;
        int            win;
        edge_n++;
        if (reset) begin
            m_pending = '0; m_last = NR - 1; inflight.delete();
            exp_grant = '0; exp_resp_valid = '0; exp_resp_prod = '0;
            exp_mult_a = '0; exp_mult_b = '0; exp_issue = 1'b0; exp_busy = 1'b0;
            return;
        end
        elig = bus.req & ~m_pending;
        exp_resp_valid = '0;
        for (int k = inflight.size() - 1; k >= 0; k--) begin
            if (inflight[k].due == edge_n) begin
                exp_resp_valid[inflight[k].idx] = 1'b1;
                exp_resp_prod = inflight[k].prod;
                m_pending[inflight[k].idx] = 1'b0;
                inflight.delete(k);
            end
        end
        win = -1;
`ifdef MULT_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < NR; k++) if (win < 0 && elig[k]) win = k;
`else
        for (int k = 1; k <= NR; k++) if (win < 0 && elig[(m_last + k) % NR]) win = (m_last + k) % NR;
`endif
        exp_grant = '0;
        exp_issue = (win >= 0);
        if (win >= 0) begin
            exp_grant[win] = 1'b1;
            m_pending[win] = 1'b1;
            m_last = win;
            exp_mult_a = op_a[win];
            exp_mult_b = op_b[win];
            inflight.push_back('{idx: win, prod: DW'(op_a[win] * op_b[win]), due: edge_n + MD + 1});
        end
        exp_busy = |m_pending;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*DW +: DW] = op_a[i];
            bus.req_b[i*DW +: DW] = op_b[i];
        end
    endtask

    task automatic tick();
        drive_ops();
        model_step();
        @(negedge clock);
        check_val("grant", DW'(bus.grant), DW'(exp_grant));
        check_val("resp_valid", DW'(bus.resp_valid), DW'(exp_resp_valid));
        check_val("resp_prod", bus.resp_prod, exp_resp_prod);
        check_val("mult_issue", DW'(bus.mult_issue), DW'(exp_issue));
        check_val("mult_a", bus.mult_a, exp_mult_a);
        check_val("mult_b", bus.mult_b, exp_mult_b);
        check_val("busy", DW'(bus.busy), DW'(exp_busy));
        if (bus.grant != '0)
            $display("t=%0t grant=%b a=%h b=%h", $time, bus.grant, bus.mult_a, bus.mult_b);
        if (bus.resp_valid != '0)
            $display("t=%0t resp_valid=%b prod=%h", $time, bus.resp_valid, bus.resp_prod);
    endtask

    function automatic logic [DW-1:0] rand_op();
        return ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 255));
    endfunction

    // Requesters keep operands stable while waiting; they change them only when idle or just granted.
    task automatic gen_inputs(input bit hold_all);
        for (int i = 0; i < NR; i++) begin
            if (exp_grant[i]) begin
                op_a[i] = rand_op(); op_b[i] = rand_op();
                bus.req[i] = hold_all ? 1'b1 : ($urandom_range(0, 3) != 0);
            end else if (!bus.req[i]) begin
                if (hold_all || $urandom_range(0, 2) == 0) begin
                    op_a[i] = rand_op(); op_b[i] = rand_op();
                    bus.req[i] = 1'b1;
                end
            end else if (!hold_all && $urandom_range(0, 9) == 0) begin
                bus.req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        edge_n = 0;
        reset = 1'b1;
        bus.req = '0;
        for (int i = 0; i < NR; i++) begin op_a[i] = '0; op_b[i] = '0; end
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single request from requester 2: 7*6 comes back five cycles after its grant.
        op_a[2] = 32'd7; op_b[2] = 32'd6; bus.req = 4'b0100;
        tick();
        check_val("single_grant", DW'(bus.grant), DW'(4'b0100));
        bus.req = '0;
        repeat (5) tick();
        check_val("single_resp_valid", DW'(bus.resp_valid), DW'(4'b0100));
        check_val("single_resp_prod", bus.resp_prod, 32'd42);
        repeat (3) tick();

        // Every requester asserting continuously.
        repeat (40) begin gen_inputs(1'b1); tick(); end
        bus.req = '0;
        repeat (8) tick();

        repeat (400) begin gen_inputs(1'b0); tick(); end
        bus.req = '0;
        repeat (8) tick();

        // Reset two cycles after a grant: the operation in flight must vanish.
        op_a[1] = 32'd13; op_b[1] = 32'd3; bus.req = 4'b0010;
        tick();
        bus.req = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("reset_busy", DW'(bus.busy), 32'd0);
        check_val("reset_mult_a", bus.mult_a, 32'd0);
        reset = 1'b0;
        repeat (8) tick();

        repeat (300) begin gen_inputs(1'b0); tick(); end
        bus.req = '0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin scheduler sharing one fixed-latency pipelined multiplier among `NUM_REQ` requesters, such as several `exponent_operation`-style sequencers. It accepts level requests carrying operands, issues at most one operation per cycle to the multiplier and routes each product back to its originator via a latency-matched tag pipeline. Each requester may have at most one operation in flight.

## Interface
- `DATA_WIDTH`, 32, operand/product width
- `NUM_REQ`, 4, number of requesters (2..16)
- `MULT_DELAY`, 4, multiplier latency in cycles from issue to product (>=1)
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  per-requester request level
- `req_a`  in  NUM_REQ*DATA_WIDTH  operand A; slice i = `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_b`  in  NUM_REQ*DATA_WIDTH  operand B, same packing
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse marking operand capture
- `resp_valid`  out  NUM_REQ  one-hot, one-cycle pulse marking a product for requester i
- `resp_prod`  out  DATA_WIDTH  product, shared bus, valid only with `resp_valid`
- `mult_a`, `mult_b`  out  DATA_WIDTH  multiplier operands
- `mult_issue`  out  1  operands valid this cycle
- `mult_prod`  in  DATA_WIDTH  multiplier result, valid exactly `MULT_DELAY` cycles after `mult_issue`
- `busy`  out  1  any operation in flight

## Operation
- `pending[i]`: set on edge where `grant[i]` asserts; cleared on edge where `resp_valid[i]` asserts.
- Eligible set: `req & ~pending`. At each edge, if any bit is eligible, the winner is registered: `grant[winner]`=1, `mult_a/mult_b` = winner's operands, `mult_issue`=1, `pending[winner]` set. Otherwise `grant`=0 and `mult_issue`=0; `mult_a/mult_b` hold their previous value.
- Round-robin: pointer `last` = index of last grant (reset `NUM_REQ-1`); search order `last+1 ... last`, wrapping modulo `NUM_REQ`.
- Tag pipeline: `MULT_DELAY` stages of {valid, index}; stage 0 is loaded alongside `mult_issue`. When the final stage is valid, `resp_valid[index]`=1 and `resp_prod`=`mult_prod`, both registered on the same edge.
- Requesters hold operands stable while `req`=1 and ungranted. `req` still high after `resp_valid` counts as a new request.
- `busy` = OR of `pending`.
- Reset values: `grant`=0, `resp_valid`=0, `resp_prod`=0, `mult_a`=0, `mult_b`=0, `mult_issue`=0, `busy`=0, `pending`=0, tag pipeline cleared, `last`=`NUM_REQ-1`.

## Timing
- Request sampled at edge E: `grant` and `mult_issue` are high in cycle E+1. `resp_valid` is high in cycle E+1+`MULT_DELAY`+1. Product sampled from `mult_prod` at cycle E+1+`MULT_DELAY` is registered out.
- Throughput: one issue per cycle when distinct requesters are eligible.
- The same requester can be re-granted no earlier than the cycle after its `resp_valid`.
- `req` deasserted before its grant edge: no grant, no state change.
- Reset mid-operation: all in-flight tags are discarded. No `resp_valid` fires for them, including products still emerging from the multiplier.
- A `resp_valid` and a `grant` on the same edge, for different or the same requester, are independent and both take effect.

## Configuration
- `MULT_ARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest eligible index wins; `last` is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Single request, NUM_REQ=4, MULT_DELAY=4. `req[2]`=1, a=7, b=6 sampled at E -> `grant`=4'b0100 at E+1, `mult_a`=7, `mult_b`=6. `resp_valid`=4'b0100 with `resp_prod`=42 at E+6. No other pulses.
- All four requesters request continuously from reset -> grants in order 0,1,2,3 on four consecutive cycles. Each `resp_valid` arrives 5 cycles after its grant. Re-grants start with 0 after its response.
- Same all-request stimulus with `MULT_ARB_FIXED_PRIORITY_EN` defined -> grant order 0,1,2,3 first round. Once 0 is responded, 0 regains priority ahead of 1, 2 and 3.
- Back-to-back responses: operands (3,5),(2,9),(11,11) issued on consecutive cycles from requesters 0, 1 and 3 -> `resp_prod` 15, 18, 121 on consecutive cycles with matching one-hot `resp_valid`.
- Held request: `req[1]` kept high through grant -> exactly one grant until its `resp_valid`, then a second grant on the next cycle.
- Reset asserted two cycles after a grant -> all outputs return to zero. No `resp_valid` for the discarded operation. `busy`=0.
